// File: rtl/fractal_iter_seq_if.sv
// Job/result bundle for the sequential escape-time engine.
//   start_valid/start_ready : job handshake; x, y, c, thres, mode sampled on accept
//   res_valid/res_ready     : result handshake; iter_cnt, escaped held while res_valid
//   busy                    : engine is iterating
// master = job producer / result consumer, slave = the engine.
interface fractal_iter_seq_if #(
  parameter int WS      = 16,
  parameter int ITER_WS = 7
);
  logic                 start_valid;
  logic                 start_ready;
  logic [WS-1:0]        x;
  logic [WS-1:0]        y;
  logic [2*WS-1:0]      c;
  logic [WS-1:0]        thres;
  logic                 mode;
  logic                 res_valid;
  logic                 res_ready;
  logic [ITER_WS-1:0]   iter_cnt;
  logic                 escaped;
  logic                 busy;

  modport master (
    output start_valid, x, y, c, thres, mode, res_ready,
    input  start_ready, res_valid, iter_cnt, escaped, busy
  );

  modport slave (
    input  start_valid, x, y, c, thres, mode, res_ready,
    output start_ready, res_valid, iter_cnt, escaped, busy
  );
endinterface

// File: rtl/fractal_iter_seq.sv
// Sequential escape-time engine: one z <= z^2 + c step per clock, Julia or Mandelbrot.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; aborts any running job
//   bus  : slave side of fractal_iter_seq_if (job in, result out, busy)
// Fixed point: WS-bit signed words with DP fraction bits; products wrap.
module fractal_iter_seq #(
  parameter int WS       = 16,
  parameter int DP       = 8,
  parameter int MAX_ITER = 64,
  parameter int ITER_WS  = 7,
  parameter int X_OFF    = 640,
  parameter int Y_OFF    = 360
) (
  input logic               clk,
  input logic               rst,
  fractal_iter_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic signed [WS-1:0] zr_q, zr_d, zi_q, zi_d;
  logic signed [WS-1:0] cr_q, cr_d, ci_q, ci_d;
  logic [WS-1:0]        thres_q, thres_d;
  logic [ITER_WS-1:0]   k_q, k_d, iter_q, iter_d;
  logic                 esc_q, esc_d;

  logic signed [2*WS-1:0] rr_full, ii_full, ri_full;
  logic signed [WS-1:0]   rr, ii, ri, pr, pi;
  logic [WS:0]            mag;
  logic                   escape_now, last_iter, accept;
  logic                   unused_bits;

  // Full-width signed products; the fixed-point result is the WS-bit window above DP.
  assign rr_full = zr_q * zr_q;
  assign ii_full = zi_q * zi_q;
  assign ri_full = zr_q * zi_q;
  assign rr = rr_full[DP +: WS];
  assign ii = ii_full[DP +: WS];
  assign ri = ri_full[DP +: WS];
  assign unused_bits = ^{rr_full[2*WS-1:DP+WS], rr_full[DP-1:0],
                         ii_full[2*WS-1:DP+WS], ii_full[DP-1:0],
                         ri_full[2*WS-1:DP+WS], ri_full[DP-1:0]};

  // Pixel to complex point, wrapping modulo 2^WS.
  assign pr = bus.x - WS'(X_OFF);
  assign pi = bus.y - WS'(Y_OFF);

  // Squares read as unsigned and summed one bit wider so the sum cannot overflow.
  assign mag        = {1'b0, rr} + {1'b0, ii};
  assign escape_now = mag > {1'b0, thres_q};
  assign last_iter  = k_q == ITER_WS'(MAX_ITER - 1);

  assign bus.start_ready = !rst && (state_q == ST_IDLE ||
                                    (state_q == ST_DONE && bus.res_ready));
  assign accept          = bus.start_valid && bus.start_ready;
  assign bus.res_valid   = state_q == ST_DONE;
  assign bus.busy        = state_q == ST_ITER;
  assign bus.iter_cnt    = iter_q;
  assign bus.escaped     = esc_q;

  always_comb begin
    state_d = state_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    thres_d = thres_q;
    k_d     = k_q;
    iter_d  = iter_q;
    esc_d   = esc_q;

    case (state_q)
      ST_IDLE: ;
      ST_ITER: begin
        if (escape_now) begin
          iter_d  = k_q;
          esc_d   = 1'b1;
          state_d = ST_DONE;
        end else if (last_iter) begin
          iter_d  = ITER_WS'(MAX_ITER);
          esc_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          zr_d = rr - ii + cr_q;
          zi_d = ri + ri + ci_q;
          k_d  = k_q + ITER_WS'(1);
        end
      end
      ST_DONE: if (bus.res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new job overrides the DONE->IDLE move, giving zero-bubble back-to-back jobs.
    // mode only steers what gets loaded here, so it needs no register of its own.
    if (accept) begin
      state_d = ST_ITER;
      k_d     = '0;
      thres_d = bus.thres;
      if (bus.mode) begin
        zr_d = '0;
        zi_d = '0;
        cr_d = pr;
        ci_d = pi;
      end else begin
        zr_d = pr;
        zi_d = pi;
        cr_d = bus.c[WS-1:0];
        ci_d = bus.c[2*WS-1:WS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      zr_q    <= '0;
      zi_q    <= '0;
      cr_q    <= '0;
      ci_q    <= '0;
      thres_q <= '0;
      k_q     <= '0;
      iter_q  <= '0;
      esc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      thres_q <= thres_d;
      k_q     <= k_d;
      iter_q  <= iter_d;
      esc_q   <= esc_d;
    end
  end

endmodule

// File: tb/tb_fractal_iter_seq.sv
// Self-checking bench for fractal_iter_seq: vector table, corner sequences, random jobs
// checked against an arithmetic escape-time model.
module tb_fractal_iter_seq;

  localparam int WS       = 16;
  localparam int DP       = 8;
  localparam int MAX_ITER = 64;
  localparam int ITER_WS  = 7;

  typedef struct {
    logic        mode;
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] c;
    logic [15:0] thres;
    int          exp_iter;
    logic        exp_esc;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  fractal_iter_seq_if #(.WS(WS), .ITER_WS(ITER_WS)) bus ();

  fractal_iter_seq #(
    .WS(WS), .DP(DP), .MAX_ITER(MAX_ITER), .ITER_WS(ITER_WS), .X_OFF(640), .Y_OFF(360)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: plain integer arithmetic ----------------
  function automatic longint wrap(input longint v);
    longint r;
    r = v & ((64'd1 << WS) - 1);
    if (r >= (64'd1 << (WS - 1))) r -= (64'd1 << WS);
    return r;
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return wrap((a * b) >>> DP);
  endfunction

  function automatic void model(input vec_t v, output int it, output logic esc);
    longint px, py, zr, zi, cr, ci, sr, si, nr, m;
    px = wrap(longint'(v.x) - 640);
    py = wrap(longint'(v.y) - 360);
    if (v.mode) begin
      zr = 0; zi = 0; cr = px; ci = py;
    end else begin
      zr = px; zi = py;
      cr = wrap(longint'(v.c[15:0]));
      ci = wrap(longint'(v.c[31:16]));
    end
    for (int k = 0; k < MAX_ITER; k++) begin
      sr = fmul(zr, zr);
      si = fmul(zi, zi);
      m  = (sr & 64'hFFFF) + (si & 64'hFFFF);
      if (m > longint'(v.thres)) begin
        it = k; esc = 1'b1;
        return;
      end
      nr = wrap(sr - si + cr);
      zi = wrap(2 * fmul(zr, zi) + ci);
      zr = nr;
    end
    it = MAX_ITER; esc = 1'b0;
  endfunction

  function automatic vec_t mk(input logic mode, input int x, input int y, input logic [31:0] c,
                              input int thres, input int it, input logic esc, input int lat);
    vec_t v;
    v.mode = mode; v.x = 16'(x); v.y = 16'(y); v.c = c; v.thres = 16'(thres);
    v.exp_iter = it; v.exp_esc = esc; v.exp_lat = lat;
    return v;
  endfunction

  // ---------------- driver helpers ----------------
  task automatic drive(input vec_t v);
    bus.mode = v.mode; bus.x = v.x; bus.y = v.y; bus.c = v.c; bus.thres = v.thres;
  endtask

  // Returns #1 after the accept edge.
  task automatic start_job(input vec_t v, input string name);
    int n;
    drive(v);
    bus.start_valid = 1'b1;
    n = 0;
    while (!bus.start_ready && n < 200) begin
      tick();
      n++;
    end
    check({name, " start_ready"}, 64'(bus.start_ready), 64'd1);
    tick();
    bus.start_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, output int it, output logic esc,
                             output int lat);
    lat = 0;
    while (!bus.res_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({name, " res_valid"}, 64'(bus.res_valid), 64'd1);
    it  = int'(bus.iter_cnt);
    esc = bus.escaped;
  endtask

  task automatic handshake(input string name);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({name, " res_valid drop"}, 64'(bus.res_valid), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int it, lat;
    logic esc;
    start_job(v, name);
    wait_result(name, it, esc, lat);
    check({name, " iter_cnt"}, 64'(it), 64'(v.exp_iter));
    check({name, " escaped"}, 64'(esc), 64'(v.exp_esc));
    check({name, " latency"}, 64'(lat), 64'(v.exp_lat));
    handshake(name);
  endtask

  vec_t tbl[$];
  vec_t s1, s2, s3, rv;

  initial begin
    int it, lat, bad, tmp;
    logic esc;

    bus.start_valid = 1'b0; bus.res_ready = 1'b0;
    bus.mode = 1'b0; bus.x = '0; bus.y = '0; bus.c = '0; bus.thres = '0;

    s1 = mk(1'b0, 640, 360, 32'h0, 1024, 64, 1'b0, 64);
    s2 = mk(1'b0, 1408, 360, 32'h0, 1024, 0, 1'b1, 1);
    s3 = mk(1'b1, 896, 360, 32'h0, 1024, 3, 1'b1, 4);
    tbl.push_back(s1);
    tbl.push_back(s2);
    tbl.push_back(s3);
    tbl.push_back(mk(1'b0, 896, 360, 32'h0, 1024, 64, 1'b0, 64));     // fixed point z=1.0
    tbl.push_back(mk(1'b1, 640, 872, 32'h0, 1024, 2, 1'b1, 3));       // c=2i, equality at k=1
    tbl.push_back(mk(1'b0, 641, 360, 32'h0, 0, 64, 1'b0, 64));        // |z|^2 == 0 == thres
    tbl.push_back(mk(1'b0, 656, 360, 32'h0, 0, 0, 1'b1, 1));          // 1 lsb over thres 0
    tbl.push_back(mk(1'b0, 4480, 360, 32'h0, 65535, 64, 1'b0, 64));   // max thres, wrapping

    // Reset state
    tick(); tick();
    check("reset res_valid", 64'(bus.res_valid), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset iter_cnt", 64'(bus.iter_cnt), 64'd0);
    check("reset escaped", 64'(bus.escaped), 64'd0);
    check("reset start_ready", 64'(bus.start_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("post-reset start_ready", 64'(bus.start_ready), 64'd1);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Held result with res_ready low, then same-cycle handshake + new accept
    start_job(s2, "hold");
    wait_result("hold", it, esc, lat);
    drive(s3);
    bus.start_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.res_valid !== 1'b1 || bus.iter_cnt !== 7'd0 || bus.escaped !== 1'b1 ||
          bus.start_ready !== 1'b0) bad++;
      tick();
    end
    check("hold stable cycles bad", 64'(bad), 64'd0);
    bus.res_ready = 1'b1;
    #1;
    check("b2b start_ready", 64'(bus.start_ready), 64'd1);
    tick();
    bus.res_ready = 1'b0;
    bus.start_valid = 1'b0;
    check("b2b busy", 64'(bus.busy), 64'd1);
    check("b2b res_valid", 64'(bus.res_valid), 64'd0);
    wait_result("b2b", it, esc, lat);
    check("b2b iter_cnt", 64'(it), 64'd3);
    check("b2b latency", 64'(lat), 64'd4);
    handshake("b2b");

    // Reset mid-ITER aborts the job
    start_job(s1, "abort");
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("abort start_ready in rst", 64'(bus.start_ready), 64'd0);
    tick();
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort res_valid", 64'(bus.res_valid), 64'd0);
    check("abort iter_cnt", 64'(bus.iter_cnt), 64'd0);
    rst = 1'b0;
    #1;
    check("abort start_ready after", 64'(bus.start_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      if (bus.res_valid !== 1'b0) bad++;
      tick();
    end
    check("abort no result", 64'(bad), 64'd0);
    run_vec(s3, "rerun");

    // Inputs changed after accept must not affect the job
    start_job(s3, "late");
    bus.x = '0; bus.c = 32'h7FFF7FFF; bus.mode = 1'b0;
    wait_result("late", it, esc, lat);
    check("late iter_cnt", 64'(it), 64'd3);
    check("late escaped", 64'(esc), 64'd1);
    handshake("late");

    // Random jobs against the model
    for (int j = 0; j < 40; j++) begin
      rv.mode = 1'($urandom_range(0, 1));
      tmp = 40 + int'($urandom_range(0, 1200)); rv.x = 16'(tmp);
      tmp = int'($urandom_range(0, 720));       rv.y = 16'(tmp);
      tmp = int'($urandom_range(0, 1024)) - 512; rv.c[15:0] = 16'(tmp);
      tmp = int'($urandom_range(0, 1024)) - 512; rv.c[31:16] = 16'(tmp);
      tmp = int'($urandom_range(256, 2048));    rv.thres = 16'(tmp);
      model(rv, rv.exp_iter, rv.exp_esc);
      rv.exp_lat = rv.exp_esc ? rv.exp_iter + 1 : MAX_ITER;
      run_vec(rv, $sformatf("rand%0d", j));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fractal_iter_seq.md
Name: fractal_iter_seq

Overview:
- Sequential, handshaked escape-time engine for the fractal renderer. Computes one complex-quadratic iteration z <= z^2 + c per clock, instead of one unrolled combinational stage per iteration.
- Maps a pixel (x, y) to a fixed-point complex point and runs in Julia or Mandelbrot mode.
- Returns a binary iteration count plus an escape flag.
- Width, fraction bits, iteration depth and screen offsets are parametrised.

Parameters:
- WS, 16, total fixed-point word width (signed two's complement).
- DP, 8, fraction bits; 1.0 = 2^DP raw.
- MAX_ITER, 64, maximum number of escape tests per job.
- ITER_WS, 7, width of iter_cnt; must satisfy 2^ITER_WS > MAX_ITER.
- X_OFF, 640, pixel x offset subtracted to form the real part.
- Y_OFF, 360, pixel y offset subtracted to form the imaginary part.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  job request.
- start_ready  out  1  engine can accept a job this cycle.
- x  in  WS  pixel x coordinate (unsigned).
- y  in  WS  pixel y coordinate (unsigned).
- c  in  2*WS  complex constant; imag in [2*WS-1:WS], real in [WS-1:0]. Used in Julia mode only.
- thres  in  WS  escape threshold on |z|^2; treated as unsigned.
- mode  in  1  0 = Julia (z0 = pixel, c = c input); 1 = Mandelbrot (z0 = 0, c = pixel).
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- iter_cnt  out  ITER_WS  escape iteration index, or MAX_ITER if no escape.
- escaped  out  1  1 = threshold exceeded; 0 = MAX_ITER reached without escape.
- busy  out  1  state is ITER.

Behaviour:
- Pixel mapping: pr = x - X_OFF, pi = y - Y_OFF, modulo 2^WS. Results are used as raw fixed-point values, so one pixel = 2^-DP.
- Fixed-point multiply: full 2*WS signed product, arithmetic shift right by DP, truncate to WS. Wraps; no saturation.
- Iteration step: re' = zr*zr - zi*zi + cr; im' = 2*zr*zi + ci. Both WS-bit wrapping.
- Escape magnitude: |z|^2 = zr*zr + zi*zi, each square shifted by DP, summed at WS+1 bits unsigned (no overflow).
- Escape test: escape when |z|^2 > {0, thres}. Equality does not escape.
- FSM states: IDLE, ITER, DONE. Reset state is IDLE.
- start_ready = !rst && (state==IDLE || (state==DONE && res_ready)).
- On accept (start_valid && start_ready):
  - latch c, thres and mode;
  - load z0 (pixel in Julia mode, 0 in Mandelbrot mode);
  - load the working c (c input in Julia mode, pixel in Mandelbrot mode);
  - set k = 0 and go to ITER.
- Inputs are sampled only in the accept cycle. Later input changes have no effect on the running job.
- Each ITER cycle tests z_k:
  - escape: iter_cnt <= k, escaped <= 1, go to DONE;
  - else if k == MAX_ITER-1: iter_cnt <= MAX_ITER, escaped <= 0, go to DONE;
  - else: z <= z^2 + c, k <= k+1.
- Latency, accept edge to res_valid high: k+1 cycles for escape at iteration k; MAX_ITER cycles for no escape.
- DONE: res_valid = 1. iter_cnt and escaped are held stable until res_valid && res_ready.
- On the handshake cycle in DONE: go to IDLE, or directly to ITER if a new job is accepted in the same cycle (zero-bubble back-to-back).
- In DONE with res_ready = 0: start_valid is ignored.
- res_ready is ignored outside DONE.
- busy = (state == ITER).
- Reset values: state IDLE, res_valid 0, iter_cnt 0, escaped 0, busy 0, internal z/c/k = 0. start_ready is 0 while rst is high, and 1 in the first cycle after rst falls.
- rst asserted mid-ITER or in DONE aborts the job. No result is produced, and the next edge shows the reset values.

Test Plan:
1. Julia, c=0, x=640, y=360 (z0=0), thres=1024 (4.0) -> res_valid 64 cycles after accept, iter_cnt=64, escaped=0.
2. Julia, x=1408, y=360 (z0=3.0), thres=1024 -> res_valid 1 cycle after accept, iter_cnt=0, escaped=1.
3. Mandelbrot, x=896, y=360 (c=1.0), thres=1024 -> |z|^2 sequence 0, 1, 4 (equality, no escape), 25 -> iter_cnt=3, escaped=1, latency 4 cycles.
4. After scenario 2: hold res_ready=0 for 10 cycles with start_valid=1 -> res_valid, iter_cnt and escaped stable, start_ready=0. Then res_ready=1 and start_valid=1 in the same cycle -> handshake completes and the new job is accepted that cycle (start_ready=1).
5. Start scenario 1, assert rst for 1 cycle at ITER cycle 5 -> res_valid stays 0, start_ready=1 after release. Rerun scenario 3 -> iter_cnt=3.
6. Accept scenario 3, then drive x=0, c=0x7FFF7FFF and mode=0 on cycle 1 -> result still iter_cnt=3, escaped=1.
